// File: rtl/ccff_loader.sv
// ccff_loader: streams NUM_CHAINS-bit bitstream words into the fabric's parallel ccff chains,
// then releases fabric reset. Optional CRC-16-CCITT check is enabled by defining CCFF_CRC_EN.
module ccff_loader #(
  parameter int unsigned NUM_CHAINS  = 10,
  parameter int unsigned CHAIN_LEN   = 1024,
  parameter int unsigned RELEASE_DLY = 4,
  parameter int unsigned CNT_W       = $clog2(CHAIN_LEN + 1)
) (
  input  logic                  prog_clock,
  input  logic                  global_resetn,
  input  logic                  start,
  input  logic [15:0]           crc_expected,
  input  logic                  bs_valid,
  input  logic [NUM_CHAINS-1:0] bs_data,
  output logic                  bs_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_shift,
  output logic                  fabric_resetn,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      word_cnt
);

  localparam int unsigned SET_W = $clog2(RELEASE_DLY + 1);
  localparam int unsigned CRC_W = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_SETTLE = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  shift_q, shift_d;
  logic [NUM_CHAINS-1:0] head_q, head_d;
  logic                  frst_q, frst_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SET_W-1:0]      settle_q, settle_d;
  logic                  crc_bad;

`ifdef CCFF_CRC_EN
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  logic [CRC_W-1:0] crc_q, crc_d;
  logic [CRC_W-1:0] crc_exp_q, crc_exp_d;

  // MSB-first CRC update over one word, bit 0 entering first.
  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                input logic [NUM_CHAINS-1:0] data);
    logic [CRC_W-1:0] c;
    c = crc;
    for (int i = 0; i < int'(NUM_CHAINS); i++) begin
      if (c[CRC_W-1] ^ data[i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
      else                      c = {c[CRC_W-2:0], 1'b0};
    end
    return c;
  endfunction

  assign crc_bad = (crc_q != crc_exp_q);
`else
  logic unused_crc_expected;
  assign unused_crc_expected = ^crc_expected;
  assign crc_bad             = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    shift_d  = 1'b0;
    head_d   = head_q;
    frst_d   = frst_q;
    busy_d   = busy_q;
    done_d   = done_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
`ifdef CCFF_CRC_EN
    crc_d     = crc_q;
    crc_exp_d = crc_exp_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_LOAD;
          ready_d = 1'b1;
          frst_d  = 1'b0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
`ifdef CCFF_CRC_EN
          crc_d     = CRC_INIT;
          crc_exp_d = crc_expected;
`endif
        end
      end
      S_LOAD: begin
        if (bs_valid && ready_q) begin
          shift_d = 1'b1;
          head_d  = bs_data;
          cnt_d   = cnt_q + CNT_W'(1);
`ifdef CCFF_CRC_EN
          crc_d   = crc_step(crc_q, bs_data);
`endif
          if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
            state_d  = S_SETTLE;
            ready_d  = 1'b0;
            settle_d = '0;
          end
        end
      end
      S_SETTLE: begin
        // Holds RELEASE_DLY cycles past the final shift pulse (which occupies the first cycle).
        if (settle_q == SET_W'(RELEASE_DLY)) begin
          busy_d = 1'b0;
          if (crc_bad) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_DONE;
            frst_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge prog_clock) begin
    if (!global_resetn) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      shift_q  <= 1'b0;
      head_q   <= '0;
      frst_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      settle_q <= '0;
`ifdef CCFF_CRC_EN
      crc_q     <= 16'hFFFF;
      crc_exp_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      shift_q  <= shift_d;
      head_q   <= head_d;
      frst_q   <= frst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
`ifdef CCFF_CRC_EN
      crc_q     <= crc_d;
      crc_exp_q <= crc_exp_d;
`endif
    end
  end

  assign bs_ready      = ready_q;
  assign ccff_shift    = shift_q;
  assign ccff_head     = head_q;
  assign fabric_resetn = frst_q;
  assign busy          = busy_q;
  assign cfg_done      = done_q;
  assign cfg_err       = err_q;
  assign word_cnt      = cnt_q;

endmodule

// File: tb/tb_ccff_loader.sv
// Self-checking bench for ccff_loader: phase/queue reference model compared every cycle,
// plus directed vectors with hand-computed expectations.
`timescale 1ns/1ps
module tb_ccff_loader;

  localparam int unsigned NC = 2;
  localparam int unsigned CL = 4;
  localparam int unsigned RD = 2;
  localparam int unsigned CW = $clog2(CL + 1);
`ifdef CCFF_CRC_EN
  localparam bit CRC_EN = 1'b1;
`else
  localparam bit CRC_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   crc_exp = 16'h0;
  logic          bs_valid = 1'b0;
  logic [NC-1:0] bs_data = '0;
  logic          bs_ready, ccff_shift, fabric_resetn, busy, cfg_done, cfg_err;
  logic [NC-1:0] ccff_head;
  logic [CW-1:0] word_cnt;

  ccff_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(CL), .RELEASE_DLY(RD)) dut (
    .prog_clock(clk), .global_resetn(rstn), .start(start), .crc_expected(crc_exp),
    .bs_valid(bs_valid), .bs_data(bs_data), .bs_ready(bs_ready), .ccff_head(ccff_head),
    .ccff_shift(ccff_shift), .fabric_resetn(fabric_resetn), .busy(busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: load phase plus the queue of words accepted in the current load.
  typedef enum int {P_IDLE, P_LOAD, P_SETTLE, P_DONE, P_ERR} phase_t;
  phase_t        ph = P_IDLE;
  logic [NC-1:0] words[$];
  int            since = 0;
  logic [15:0]   m_exp_crc = 16'h0;
  logic          e_shift = 1'b0;
  logic [NC-1:0] e_head = '0;

  function automatic logic [15:0] bitstream_crc();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (words[w]) begin
      for (int b = 0; b < int'(NC); b++) begin
        fb = c[15] ^ words[w][b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      ph = P_IDLE;
      words.delete();
      e_shift = 1'b0;
      e_head = '0;
    end else begin
      e_shift = 1'b0;
      case (ph)
        P_IDLE, P_DONE, P_ERR: if (start) begin
          ph = P_LOAD;
          words.delete();
          m_exp_crc = crc_exp;
        end
        P_LOAD: if (bs_valid && words.size() < int'(CL)) begin
          words.push_back(bs_data);
          e_shift = 1'b1;
          e_head = bs_data;
          if (words.size() == int'(CL)) begin
            ph = P_SETTLE;
            since = 0;
          end
        end
        P_SETTLE: begin
          since++;
          if (since == int'(RD) + 1)
            ph = (CRC_EN && bitstream_crc() != m_exp_crc) ? P_ERR : P_DONE;
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("bs_ready", 32'(bs_ready), 32'(ph == P_LOAD && words.size() < int'(CL)));
      check("ccff_shift", 32'(ccff_shift), 32'(e_shift));
      check("ccff_head", 32'(ccff_head), 32'(e_head));
      check("fabric_resetn", 32'(fabric_resetn), 32'(ph == P_DONE));
      check("busy", 32'(busy), 32'(ph == P_LOAD || ph == P_SETTLE));
      check("cfg_done", 32'(cfg_done), 32'(ph == P_DONE));
      check("cfg_err", 32'(cfg_err), 32'(ph == P_ERR));
      check("word_cnt", 32'(word_cnt), 32'(words.size()));
    end
  end

  // Fabric chain image built from what the DUT actually drives.
  logic [NC-1:0] fab [CL];
  int shifts_seen = 0;
  always @(posedge clk) begin
    if (ccff_shift === 1'b1) begin
      shifts_seen <= shifts_seen + 1;
      for (int i = int'(CL) - 1; i > 0; i--) fab[i] <= fab[i-1];
      fab[0] <= ccff_head;
    end
  end

  task automatic step(input logic s, input logic v, input logic [NC-1:0] d);
    start = s;
    bs_valid = v;
    bs_data = d;
    @(negedge clk);
  endtask

  task automatic load_words(input logic [NC-1:0] w0, input logic [NC-1:0] w1,
                            input logic [NC-1:0] w2, input logic [NC-1:0] w3);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, w0);
    step(1'b0, 1'b1, w1);
    step(1'b0, 1'b1, w2);
    step(1'b0, 1'b1, w3);
  endtask

  task automatic wait_end();
    for (int i = 0; i < 12 && !(cfg_done === 1'b1 || cfg_err === 1'b1); i++)
      step(1'b0, 1'b0, '0);
    check("settle_end", 32'(cfg_done | cfg_err), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NC-1:0] ld [4];
    logic          sv [7];
    logic [NC-1:0] sd [7];
    int            base;
    ld[0] = 2'b01; ld[1] = 2'b10; ld[2] = 2'b11; ld[3] = 2'b00;
    sv[0] = 1; sv[1] = 0; sv[2] = 0; sv[3] = 1; sv[4] = 1; sv[5] = 0; sv[6] = 1;
    sd[0] = 2'b11; sd[1] = 2'b10; sd[2] = 2'b01; sd[3] = 2'b00;
    sd[4] = 2'b10; sd[5] = 2'b11; sd[6] = 2'b01;

    // Reset held 3 cycles with start and data asserted.
    rstn = 1'b0;
    repeat (3) step(1'b1, 1'b1, 2'b11);
    chk_en = 1'b1;
    check("rst_bs_ready", 32'(bs_ready), 32'(0));
    check("rst_shift", 32'(ccff_shift), 32'(0));
    check("rst_head", 32'(ccff_head), 32'(0));
    check("rst_fabric_resetn", 32'(fabric_resetn), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done_err", 32'({cfg_done, cfg_err}), 32'(0));
    check("rst_word_cnt", 32'(word_cnt), 32'(0));
    rstn = 1'b1;
    step(1'b0, 1'b0, '0);
    check("idle_busy", 32'(busy), 32'(0));

    // Back-to-back load.
    step(1'b1, 1'b0, '0);
    check("b2b_first_ready", 32'(bs_ready), 32'(1));
    check("b2b_first_busy", 32'(busy), 32'(1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, ld[i]);
      check("b2b_shift", 32'(ccff_shift), 32'(1));
      check("b2b_head", 32'(ccff_head), 32'(ld[i]));
    end
    check("b2b_cnt", 32'(word_cnt), 32'(4));
    check("b2b_ready_low", 32'(bs_ready), 32'(0));
    step(1'b0, 1'b0, '0);
    check("b2b_settle1_frst", 32'(fabric_resetn), 32'(0));
    check("b2b_settle1_shift", 32'(ccff_shift), 32'(0));
    step(1'b0, 1'b0, '0);
    check("b2b_settle2_frst", 32'(fabric_resetn), 32'(0));
    step(1'b0, 1'b0, '0);
    check("b2b_release_frst", 32'(fabric_resetn), 32'(1));
    check("b2b_done", 32'(cfg_done), 32'(1));
    check("b2b_busy_low", 32'(busy), 32'(0));
    check("b2b_chain_tail", 32'(fab[CL-1]), 32'(2'b01));
    check("b2b_chain_head", 32'(fab[0]), 32'(2'b00));

    // Reload from DONE with a stalled stream, then offer a fifth word.
    base = shifts_seen;
    step(1'b1, 1'b0, '0);
    check("reload_frst_low", 32'(fabric_resetn), 32'(0));
    check("reload_done_low", 32'(cfg_done), 32'(0));
    check("reload_cnt_clr", 32'(word_cnt), 32'(0));
    for (int i = 0; i < 7; i++) begin
      step(1'b0, sv[i], sd[i]);
      check("stall_shift", 32'(ccff_shift), 32'(sv[i]));
    end
    step(1'b0, 1'b1, 2'b10);
    check("fifth_word_cnt", 32'(word_cnt), 32'(4));
    check("fifth_word_shift", 32'(ccff_shift), 32'(0));
    wait_end();
    check("stall_shift_total", 32'(shifts_seen - base), 32'(4));
    check("stall_chain_tail", 32'(fab[CL-1]), 32'(2'b11));
    check("stall_chain_head", 32'(fab[0]), 32'(2'b01));

    // Reset in the middle of a load.
    step(1'b1, 1'b0, '0);
    base = shifts_seen;
    step(1'b0, 1'b1, 2'b01);
    step(1'b0, 1'b1, 2'b10);
    rstn = 1'b0;
    step(1'b0, 1'b1, 2'b11);
    rstn = 1'b1;
    check("midrst_cnt", 32'(word_cnt), 32'(0));
    check("midrst_frst", 32'(fabric_resetn), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    repeat (3) step(1'b0, 1'b1, 2'b11);
    check("midrst_shift_total", 32'(shifts_seen - base), 32'(2));
    check("midrst_ready", 32'(bs_ready), 32'(0));

    // CRC of words 01,10,11,00 (bit 0 first) is 0xA3C5; first load carries a one-bit-off value.
    crc_exp = 16'hA3C5 ^ 16'h0010;
    load_words(ld[0], ld[1], ld[2], ld[3]);
    check("model_crc", 32'(bitstream_crc()), 32'(16'hA3C5));
    wait_end();
`ifdef CCFF_CRC_EN
    check("crc_bad_err", 32'(cfg_err), 32'(1));
    check("crc_bad_frst", 32'(fabric_resetn), 32'(0));
    crc_exp = 16'hA3C5;
    step(1'b1, 1'b0, '0);
    check("err_restart_clr", 32'(cfg_err), 32'(0));
    step(1'b0, 1'b1, ld[0]);
    step(1'b0, 1'b1, ld[1]);
    step(1'b0, 1'b1, ld[2]);
    step(1'b0, 1'b1, ld[3]);
    wait_end();
    check("crc_good_done", 32'(cfg_done), 32'(1));
    check("crc_good_err", 32'(cfg_err), 32'(0));
`else
    check("nocrc_done", 32'(cfg_done), 32'(1));
    check("nocrc_err", 32'(cfg_err), 32'(0));
`endif
    step(1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
